// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg: shared types, default sizes and the parity helper for the
// ram_dp_init dual-port RAM.
//   ram_state_e  - sequencer states (INIT zero-fill sweep, RUN open ports)
//   parity_f     - even parity (XOR reduction) over a zero-extended vector
//   DATA_W_DEF / ADDR_W_DEF - default word width and address width
package ram_dp_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 4;

   // Widest word parity_f can cover; callers zero-extend to this width.
   localparam int unsigned PAR_W_MAX = 64;

   typedef enum logic {
      INIT,
      RUN
   } ram_state_e;

   // Even parity bit: makes the XOR of word plus parity bit zero.
   function automatic logic parity_f(input logic [PAR_W_MAX-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/ram_dp_if.sv
// ram_dp_if: request/response bundle of the ram_dp_init dual-port RAM.
//   master modport: requester side (drives clr, write and read requests)
//   slave modport : RAM side (drives readies, read results, init_done)
// clk and rst_n are plain ports of the RAM, not part of this bundle.
interface ram_dp_if #(
   parameter int unsigned DATA_W = ram_dp_pkg::DATA_W_DEF,
   parameter int unsigned ADDR_W = ram_dp_pkg::ADDR_W_DEF
);

   logic              clr;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;
   logic              init_done;
   logic              rd_par_err;

   modport master (
      output clr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
      input  wr_ready, rd_ready, rd_data, rd_data_valid, init_done, rd_par_err
   );

   modport slave (
      input  clr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
      output wr_ready, rd_ready, rd_data, rd_data_valid, init_done, rd_par_err
   );

endinterface

// File: rtl/ram_dp_array.sv
// ram_dp_array: plain storage, 2**ADDR_W words of WIDTH bits.
//   clk           - rising-edge clock
//   we/waddr/wdata- synchronous write port
//   re/raddr      - synchronous read request; rdata updates only when re=1
//   rdata         - registered read data (old contents on same-address write)
module ram_dp_array #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ram_dp_init.sv
// ram_dp_init: simple dual-port synchronous RAM with zero-fill sequencer.
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - ram_dp_if.slave: clr, wr_valid/wr_ready/wr_addr/wr_data,
//           rd_valid/rd_ready/rd_addr, rd_data/rd_data_valid, init_done,
//           rd_par_err
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), OUT_REG (0: read latency
// 1 cycle, 1: latency 2 cycles).
// Build macro RAM_DP_PARITY_EN: stores an even-parity bit per word and
// flags rd_par_err on read mismatch; when undefined rd_par_err is 0.
// DATA_W is limited to ram_dp_pkg::PAR_W_MAX when parity is enabled.
module ram_dp_init
   import ram_dp_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned OUT_REG = 0
) (
   input  logic    clk,
   input  logic    rst_n,
   ram_dp_if.slave bus
);

`ifdef RAM_DP_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   ram_state_e        state;
   logic [ADDR_W-1:0] cnt;
   logic              open_q;

   logic              wr_fire;
   logic              rd_fire;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  mem_q;

   logic              v1;
   logic              byp1;
   logic [DATA_W-1:0] bdata1;
   logic [DATA_W-1:0] d1;
   logic              err1;

   assign wr_fire = bus.wr_valid & open_q;
   assign rd_fire = bus.rd_valid & open_q;

   assign bus.wr_ready  = open_q;
   assign bus.rd_ready  = open_q;
   assign bus.init_done = open_q;

   // Sequencer: INIT sweeps every address once with zeros, then opens ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= INIT;
         cnt    <= '0;
         open_q <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1) begin
                  state  <= RUN;
                  open_q <= 1'b1;
               end
            end
            RUN: begin
               if (bus.clr) begin
                  state  <= INIT;
                  cnt    <= '0;
                  open_q <= 1'b0;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   always_comb begin
      mem_we    = wr_fire;
      mem_waddr = bus.wr_addr;
`ifdef RAM_DP_PARITY_EN
      mem_wdata = {parity_f(PAR_W_MAX'(bus.wr_data)), bus.wr_data};
`else
      mem_wdata = bus.wr_data;
`endif
      if (state == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = cnt;
         mem_wdata = '0;
      end
   end

   ram_dp_array #(
      .WIDTH  (MEM_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (rd_fire),
      .raddr (bus.rd_addr),
      .rdata (mem_q)
   );

   // Stage 1 tracks the array read. byp1 resets to 1 with bdata1=0 so the
   // unreset array output is masked and rd_data reads 0 until the first read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         byp1   <= 1'b1;
         bdata1 <= '0;
      end else begin
         v1 <= rd_fire;
         if (rd_fire) begin
            byp1   <= wr_fire && (bus.wr_addr == bus.rd_addr);
            bdata1 <= bus.wr_data;
         end
      end
   end

   assign d1 = byp1 ? bdata1 : mem_q[DATA_W-1:0];

`ifdef RAM_DP_PARITY_EN
   assign err1 = v1 & ~byp1 &
                 (parity_f(PAR_W_MAX'(mem_q[DATA_W-1:0])) != mem_q[DATA_W]);
`else
   assign err1 = 1'b0;
`endif

   generate
      if (OUT_REG == 0) begin : g_lat1
         assign bus.rd_data       = d1;
         assign bus.rd_data_valid = v1;
         assign bus.rd_par_err    = err1;
      end else begin : g_lat2
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bus.rd_data       <= '0;
               bus.rd_data_valid <= 1'b0;
               bus.rd_par_err    <= 1'b0;
            end else begin
               bus.rd_data_valid <= v1;
               bus.rd_par_err    <= err1;
               if (v1) bus.rd_data <= d1;
            end
         end
      end
   endgenerate

endmodule
